dff_reg_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one D-flip-flop storage register (WIDTH bits, built from D_flipflop cells) among NREQ requesters. It picks one requester, drives that requester's data and a single-cycle load strobe into the shared register, holds ownership for a programmable settle time, then acknowledges the requester. It sits between requester logic and the shared register bank in the experiment datapath.

---
 rtl/dff_reg_arbiter.sv | 130 +++++++++++++
 tb/tb_dff_reg_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dff_reg_arbiter.sv
// Round-robin arbiter that lends one shared D-flip-flop register to NREQ requesters.
// Each grant drives a one-cycle load strobe, waits HOLD settle cycles, then pulses ack.
module dff_reg_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int HOLD  = 2
) (
    input  logic                   clk,
    input  logic                   Rd,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*WIDTH-1:0]  wdata,
    output logic [NREQ-1:0]        gnt,
    output logic [2:0]             owner,
    output logic [WIDTH-1:0]       reg_d,
    output logic                   reg_load,
    output logic [NREQ-1:0]        ack,
    output logic                   busy
);

    localparam logic [1:0]      ST_IDLE   = 2'd0;
    localparam logic [1:0]      ST_LOAD   = 2'd1;
    localparam logic [1:0]      ST_HOLD   = 2'd2;
    localparam logic [1:0]      ST_ACK    = 2'd3;
    localparam logic [2:0]      PTR_INIT  = 3'(NREQ - 1);
    localparam logic [3:0]      HOLD_INIT = 4'(HOLD - 1);
    localparam logic [NREQ-1:0] ONE_HOT0  = {{(NREQ-1){1'b0}}, 1'b1};

    logic [1:0]       state_r;
    logic [2:0]       ptr_r;
    logic [3:0]       cnt_r;
    logic [NREQ-1:0]  gnt_r;
    logic [2:0]       owner_r;
    logic [WIDTH-1:0] reg_d_r;
    logic             reg_load_r;
    logic [NREQ-1:0]  ack_r;
    logic             busy_r;

    logic             found_hi_s;
    logic [2:0]       idx_hi_s;
    logic [2:0]       idx_lo_s;
    logic [2:0]       win_s;
    logic [WIDTH-1:0] win_data_s;

    // Rotating priority: lowest set index above ptr wins, else lowest set index at or below ptr.
    always_comb begin
        found_hi_s = 1'b0;
        idx_hi_s   = 3'd0;
        idx_lo_s   = 3'd0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx_hi_s   = (req[i] && (3'(i) > ptr_r))  ? 3'(i) : idx_hi_s;
            idx_lo_s   = (req[i] && (3'(i) <= ptr_r)) ? 3'(i) : idx_lo_s;
            found_hi_s = found_hi_s | (req[i] && (3'(i) > ptr_r));
        end
        win_s      = found_hi_s ? idx_hi_s : idx_lo_s;
        win_data_s = {WIDTH{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            win_data_s = (3'(i) == win_s) ? wdata[i*WIDTH +: WIDTH] : win_data_s;
        end
    end

    // Sequencer: IDLE arbitrates, LOAD strobes, HOLD settles, ACK completes.
    always_ff @(posedge clk or negedge Rd) begin
        if (!Rd) begin
            state_r    <= ST_IDLE;
            ptr_r      <= PTR_INIT;
            cnt_r      <= 4'd0;
            gnt_r      <= {NREQ{1'b0}};
            owner_r    <= 3'd0;
            reg_d_r    <= {WIDTH{1'b0}};
            reg_load_r <= 1'b0;
            ack_r      <= {NREQ{1'b0}};
            busy_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (|req) begin
                        gnt_r      <= ONE_HOT0 << win_s;
                        owner_r    <= win_s;
                        reg_d_r    <= win_data_s;
                        reg_load_r <= 1'b1;
                        ptr_r      <= win_s;
                        busy_r     <= 1'b1;
                        state_r    <= ST_LOAD;
                    end else begin
                        reg_load_r <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    reg_load_r <= 1'b0;
                    if (HOLD > 0) begin
                        cnt_r   <= HOLD_INIT;
                        state_r <= ST_HOLD;
                    end else begin
                        ack_r   <= gnt_r;
                        state_r <= ST_ACK;
                    end
                end
                ST_HOLD: begin
                    if (cnt_r == 4'd0) begin
                        ack_r   <= gnt_r;
                        state_r <= ST_ACK;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                ST_ACK: begin
                    gnt_r   <= {NREQ{1'b0}};
                    ack_r   <= {NREQ{1'b0}};
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    gnt_r      <= {NREQ{1'b0}};
                    ack_r      <= {NREQ{1'b0}};
                    reg_load_r <= 1'b0;
                    busy_r     <= 1'b0;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt      = gnt_r;
    assign owner    = owner_r;
    assign reg_d    = reg_d_r;
    assign reg_load = reg_load_r;
    assign ack      = ack_r;
    assign busy     = busy_r;

endmodule

// File: tb/tb_dff_reg_arbiter.sv
// Bench for dff_reg_arbiter: HOLD=2 and HOLD=0 instances share stimulus; a transaction-level
// model predicts every grant, and a per-instance monitor checks outputs against it each cycle.
module tb_dff_reg_arbiter;

    typedef struct {
        int         edge_no;
        int         idx;
        logic [7:0] data;
    } exp_t;

    logic        clk;
    logic        Rd;
    logic [3:0]  req;
    logic [31:0] wdata;
    int          checks;
    int          failures;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    for (genvar h = 0; h < 2; h++) begin : g_dut
        localparam int H = (h == 0) ? 2 : 0;
        logic [3:0] gnt;
        logic [3:0] ack;
        logic [2:0] owner;
        logic [7:0] reg_d;
        logic       reg_load;
        logic       busy;

        dff_reg_arbiter #(.NREQ(4), .WIDTH(8), .HOLD(H)) dut (
            .clk(clk), .Rd(Rd), .req(req), .wdata(wdata),
            .gnt(gnt), .owner(owner), .reg_d(reg_d), .reg_load(reg_load),
            .ack(ack), .busy(busy)
        );

        exp_t       q[$];
        int         pend;
        int         cyc;
        int         start;
        int         ptr_m;
        int         idx_m;
        bit         active;
        logic [7:0] last_data;

        // Reference model: a transaction occupies 3+H edges; winner is the first request after ptr.
        initial begin
            cyc = 0; start = 0; ptr_m = 3; idx_m = 0; active = 1'b0; last_data = 8'h00; pend = 0;
            forever begin
                bit found;
                int cand;
                @(posedge clk or negedge Rd);
                if (!Rd) begin
                    active = 1'b0; ptr_m = 3; last_data = 8'h00; q.delete();
                end else begin
                    cyc++;
                    if (active && (cyc - start >= 3 + H)) active = 1'b0;
                    if (!active && req != 4'b0000) begin
                        found = 1'b0;
                        for (int k = 1; k <= 4; k++) begin
                            cand = (ptr_m + k) % 4;
                            if (!found && req[cand]) begin
                                found = 1'b1;
                                idx_m = cand;
                            end
                        end
                        active    = 1'b1;
                        start     = cyc;
                        ptr_m     = idx_m;
                        last_data = wdata[idx_m*8 +: 8];
                        q.push_back('{cyc, idx_m, last_data});
                    end
                end
            end
        end

        // Monitor: compare outputs with the model each falling edge; pop the queue on each load.
        initial begin
            forever begin
                int         rel;
                bit         inbusy;
                logic [3:0] oh;
                exp_t       e;
                @(negedge clk);
                if (!Rd) begin
                    chk($sformatf("h%0d_reset_outputs", H), {11'd0, gnt, ack, reg_load, busy, reg_d, owner}, 32'd0);
                end else begin
                    rel    = cyc - start;
                    oh     = 4'(1 << idx_m);
                    inbusy = active && (rel < 2 + H);
                    chk($sformatf("h%0d_busy", H), 32'(busy), 32'(inbusy));
                    chk($sformatf("h%0d_gnt", H), 32'(gnt), inbusy ? 32'(oh) : 32'd0);
                    chk($sformatf("h%0d_ack", H), 32'(ack), (active && rel == 1 + H) ? 32'(oh) : 32'd0);
                    chk($sformatf("h%0d_reg_load", H), 32'(reg_load), 32'(active && rel == 0));
                    chk($sformatf("h%0d_reg_d", H), 32'(reg_d), 32'(last_data));
                    if (inbusy) chk($sformatf("h%0d_owner", H), 32'(owner), 32'(idx_m));
                    if (reg_load) begin
                        chk($sformatf("h%0d_load_expected", H), 32'(q.size() > 0), 32'd1);
                        if (q.size() > 0) begin
                            e = q.pop_front();
                            chk($sformatf("h%0d_load_edge", H), 32'(cyc), 32'(e.edge_no));
                            chk($sformatf("h%0d_load_idx", H), 32'(owner), 32'(e.idx));
                            chk($sformatf("h%0d_load_data", H), 32'(reg_d), 32'(e.data));
                        end
                    end
                end
                pend = q.size();
            end
        end
    end

    task automatic wait_load0(input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (g_dut[0].reg_load) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int order[$];
        int loads1[$];
        int lc;
        int ac;
        bit ok;
        bit seen_ack;
        int next_owner;

        Rd = 1'b0; req = 4'b1111; wdata = 32'h44332211;
        repeat (3) @(negedge clk);
        #2 Rd = 1'b1;

        // All requesting; each drops one cycle after its ack.
        order.delete();
        repeat (30) begin
            @(negedge clk);
            if (g_dut[0].reg_load) order.push_back(int'(g_dut[0].owner));
            for (int i = 0; i < 4; i++) if (g_dut[0].ack[i]) req[i] = 1'b0;
        end
        chk("order_all_len", 32'(order.size()), 32'd4);
        for (int k = 0; k < order.size() && k < 4; k++) chk("order_all", 32'(order[k]), 32'(k));

        req = 4'b0101;
        order.delete();
        repeat (20) begin
            @(negedge clk);
            if (g_dut[0].reg_load) order.push_back(int'(g_dut[0].owner));
            for (int i = 0; i < 4; i++) if (g_dut[0].ack[i]) req[i] = 1'b0;
        end
        chk("order_02_len", 32'(order.size()), 32'd2);
        if (order.size() == 2) begin
            chk("order_02_first", 32'(order[0]), 32'd0);
            chk("order_02_second", 32'(order[1]), 32'd2);
        end

        // Single request with known data.
        req = 4'b0000;
        repeat (6) @(negedge clk);
        wdata = $urandom;
        wdata[23:16] = 8'hA5;
        req = 4'b0100;
        lc = -100; ac = -1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (g_dut[0].reg_load) begin
                lc = c;
                chk("single_reg_d", 32'(g_dut[0].reg_d), 32'h000000A5);
                chk("single_gnt", 32'(g_dut[0].gnt), 32'h4);
            end
            if (g_dut[0].ack != 4'b0000 && ac < 0) begin
                ac = c;
                chk("single_ack", 32'(g_dut[0].ack), 32'h4);
                req = 4'b0000;
            end
        end
        chk("single_ack_latency", 32'(ac - lc), 32'd3);

        // HOLD=0 instance: back-to-back loads spaced 3 cycles.
        repeat (6) @(negedge clk);
        req = 4'b0001;
        loads1.delete();
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (g_dut[1].reg_load) loads1.push_back(c);
        end
        chk("h0_spacing_count", 32'(loads1.size() >= 3), 32'd1);
        for (int k = 1; k < loads1.size(); k++) chk("h0_spacing", 32'(loads1[k] - loads1[k-1]), 32'd3);

        // Owner drops its request during HOLD; another requester waits for IDLE.
        req = 4'b0000;
        repeat (6) @(negedge clk);
        req = 4'b0010;
        wait_load0(10, ok);
        chk("drop_load_seen", 32'(ok), 32'd1);
        @(negedge clk);
        req = 4'b1000;
        seen_ack = 1'b0; next_owner = -1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (g_dut[0].ack == 4'b0010) seen_ack = 1'b1;
            if (g_dut[0].reg_load && next_owner < 0) next_owner = int'(g_dut[0].owner);
        end
        chk("drop_ack_still", 32'(seen_ack), 32'd1);
        chk("drop_next_owner", 32'(next_owner), 32'd3);

        // Reset during HOLD clears outputs immediately; pending req[1] then wins.
        req = 4'b0000;
        repeat (8) @(negedge clk);
        req = 4'b0001;
        wait_load0(10, ok);
        chk("rst_load_seen", 32'(ok), 32'd1);
        @(posedge clk);
        #3 Rd = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            if (i == 0) chk("rst_async_h2", {15'd0, g_dut[0].gnt, g_dut[0].ack, g_dut[0].reg_load, g_dut[0].busy, g_dut[0].reg_d}, 32'd0);
            else        chk("rst_async_h0", {15'd0, g_dut[1].gnt, g_dut[1].ack, g_dut[1].reg_load, g_dut[1].busy, g_dut[1].reg_d}, 32'd0);
        end
        req = 4'b0010;
        @(negedge clk);
        #2 Rd = 1'b1;
        wait_load0(10, ok);
        chk("rst_regrant_seen", 32'(ok), 32'd1);
        chk("rst_regrant_owner", 32'(g_dut[0].owner), 32'd1);
        req = 4'b0000;

        // Randomized traffic with occasional reset pulses.
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            wdata = $urandom;
            if ($urandom_range(0, 199) == 0) begin
                #2 Rd = 1'b0;
                @(negedge clk);
                #2 Rd = 1'b1;
            end
        end

        req = 4'b0000;
        repeat (12) @(negedge clk);
        chk("h2_queue_drained", 32'(g_dut[0].pend), 32'd0);
        chk("h0_queue_drained", 32'(g_dut[1].pend), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
